// File: rtl/ctrl_pkg.sv
// Shared constants for the accumulator-machine control unit: opcodes, FSM state codes, decode flags.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_pkg;

    localparam int MEM_TIMEOUT_DEF = 15;

    // Opcode map
    localparam logic [3:0] OP_NOP       = 4'h0;
    localparam logic [3:0] OP_LDI       = 4'h1;
    localparam logic [3:0] OP_ALU_FIRST = 4'h2;
    localparam logic [3:0] OP_ALU_LAST  = 4'h7;
    localparam logic [3:0] OP_ADDI      = 4'h8;
    localparam logic [3:0] OP_MOVAR     = 4'h9;
    localparam logic [3:0] OP_MOVRA     = 4'hA;
    localparam logic [3:0] OP_JMP       = 4'hB;
    localparam logic [3:0] OP_JZ        = 4'hC;
    localparam logic [3:0] OP_LD        = 4'hD;
    localparam logic [3:0] OP_ST        = 4'hE;
    localparam logic [3:0] OP_HALT      = 4'hF;

    // FSM state encoding
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    // Per-opcode behaviour flags produced by op_decode
    typedef struct packed {
        logic acc_wr;   // EXEC writes the accumulator
        logic imm;      // EXEC uses immediate as ALU operand B
        logic reg_wr;   // EXEC writes acc into the register file
        logic jmp;      // unconditional PC load
        logic jz;       // PC load when accumulator is zero
        logic mem;      // instruction needs a data-memory access
        logic st;       // data access is a write
        logic ld;       // data access loads the accumulator
        logic halt;     // stop the machine
    } op_class_t;

endpackage

// File: rtl/ctrl_unit_op_decode.sv
// Opcode-class decoder: maps a 4-bit opcode onto behaviour flags.
// Latency: combinational, zero cycles.
// Backpressure: none.
module op_decode
    import ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output op_class_t  o_cls
);

    // Flag lookup; unlisted opcodes fall through to the register ALU range check
    always_comb begin
        o_cls = '0;
        case (i_opcode)
            OP_LDI, OP_ADDI: begin
                o_cls.acc_wr = 1'b1;
                o_cls.imm    = 1'b1;
            end
            OP_MOVAR: o_cls.reg_wr = 1'b1;
            OP_MOVRA: o_cls.acc_wr = 1'b1;
            OP_JMP:   o_cls.jmp    = 1'b1;
            OP_JZ:    o_cls.jz     = 1'b1;
            OP_LD: begin
                o_cls.mem = 1'b1;
                o_cls.ld  = 1'b1;
            end
            OP_ST: begin
                o_cls.mem = 1'b1;
                o_cls.st  = 1'b1;
            end
            OP_HALT:  o_cls.halt   = 1'b1;
            default: begin
                if (i_opcode >= OP_ALU_FIRST && i_opcode <= OP_ALU_LAST) begin
                    o_cls.acc_wr = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/HALT) for a small accumulator CPU.
// Latency: pulses are combinational from state/opcode/mem_ack/zero_flag; state advances each posedge.
// Backpressure: FETCH/MEM hold mem_req until mem_ack or MEM_TIMEOUT wait cycles, then fault and halt.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel_pc,
    output logic       loadIR,
    output logic       incPC,
    output logic       loadPC,
    output logic [3:0] alu_op,
    output logic       sel_imm,
    output logic       acc_load,
    output logic       reg_write,
    output logic       halted,
    output logic       fault
);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [3:0] r_cnt;
    logic       r_fault;
    logic       w_wait;
    logic       w_timeout;
    op_class_t  w_cls;

    op_decode u_op_decode (
        .i_opcode (opcode),
        .o_cls    (w_cls)
    );

    // Timeout fires on the last permitted wait cycle only if no ack arrives (ack wins)
    assign w_wait    = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_timeout = w_wait && !mem_ack && (r_cnt == 4'(MEM_TIMEOUT - 1));

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (mem_ack)        w_next = ST_DECODE;
                else if (w_timeout) w_next = ST_HALT;
            end
            ST_DECODE: begin
                if (w_cls.halt)     w_next = ST_HALT;
                else if (w_cls.mem) w_next = ST_MEM;
                else                w_next = ST_EXEC;
            end
            ST_EXEC:  w_next = ST_FETCH;
            ST_MEM: begin
                if (mem_ack)        w_next = ST_FETCH;
                else if (w_timeout) w_next = ST_HALT;
            end
            ST_HALT:  w_next = ST_HALT;
            default:  w_next = ST_FETCH;
        endcase
    end

    // State, wait counter (restarts on every state change) and sticky fault
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wait && (w_next == r_state)) r_cnt <= r_cnt + 4'd1;
            else                               r_cnt <= '0;
            if (w_timeout) r_fault <= 1'b1;
        end
    end

    // Output decode; everything is forced low while rst is high, which also kills an in-flight access
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel_pc = 1'b0;
        loadIR     = 1'b0;
        incPC      = 1'b0;
        loadPC     = 1'b0;
        alu_op     = 4'h0;
        sel_imm    = 1'b0;
        acc_load   = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req    = 1'b1;
                    mem_sel_pc = 1'b1;
                    loadIR     = mem_ack;
                end
                ST_DECODE: incPC = 1'b1;
                ST_EXEC: begin
                    alu_op    = opcode;
                    sel_imm   = w_cls.imm;
                    acc_load  = w_cls.acc_wr;
                    reg_write = w_cls.reg_wr;
                    loadPC    = w_cls.jmp | (w_cls.jz & zero_flag);
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    mem_we   = w_cls.st;
                    acc_load = w_cls.ld & mem_ack;
                end
                ST_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign fault = r_fault & ~rst;

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: directed scenarios plus randomized instruction streams.
// Latency: inputs applied 1ns after posedge, outputs sampled at negedge.
// Backpressure: mem_ack delays are chosen by the bench; timeouts exercised explicitly.
module tb_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       zero_flag = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, mem_sel_pc, loadIR, incPC, loadPC;
    logic [3:0] alu_op;
    logic       sel_imm, acc_load, reg_write, halted, fault;

    always #5 clk = ~clk;

    ctrl_unit #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero_flag(zero_flag), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel_pc(mem_sel_pc), .loadIR(loadIR),
        .incPC(incPC), .loadPC(loadPC), .alu_op(alu_op), .sel_imm(sel_imm),
        .acc_load(acc_load), .reg_write(reg_write), .halted(halted), .fault(fault)
    );

    typedef struct packed {
        logic       mem_req, mem_we, mem_sel_pc, loadIR, incPC, loadPC;
        logic [3:0] alu_op;
        logic       sel_imm, acc_load, reg_write, halted, fault;
    } outs_t;

    // Instruction step the reference model is describing
    typedef enum int {PH_RST, PH_FETCH, PH_DECODE, PH_EXEC, PH_MEM, PH_HALT} ph_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    outs_t g, e;

    function automatic outs_t got();
        outs_t o;
        o = {mem_req, mem_we, mem_sel_pc, loadIR, incPC, loadPC, alu_op,
             sel_imm, acc_load, reg_write, halted, fault};
        return o;
    endfunction

    // Reference: what an instruction step should show, from the opcode table
    function automatic outs_t model(ph_t ph, logic [3:0] op, logic z, logic a, logic flt);
        outs_t o;
        o = '0;
        case (ph)
            PH_FETCH: begin
                o.mem_req = 1'b1; o.mem_sel_pc = 1'b1; o.loadIR = a;
            end
            PH_DECODE: o.incPC = 1'b1;
            PH_EXEC: begin
                o.alu_op    = op;
                o.sel_imm   = (op == 4'h1) || (op == 4'h8);
                o.acc_load  = ((op >= 4'h1) && (op <= 4'h8)) || (op == 4'hA);
                o.reg_write = (op == 4'h9);
                o.loadPC    = (op == 4'hB) || ((op == 4'hC) && z);
            end
            PH_MEM: begin
                o.mem_req  = 1'b1;
                o.mem_we   = (op == 4'hE);
                o.acc_load = a && (op == 4'hD);
            end
            PH_HALT: o.halted = 1'b1;
            default: ;
        endcase
        o.fault = (ph == PH_RST) ? 1'b0 : flt;
        return o;
    endfunction

    task automatic tick(input logic a, input logic [3:0] op, input logic z, input logic r);
        @(posedge clk); #1;
        mem_ack = a; opcode = op; zero_flag = z; rst = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        tick(1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        logic a, z; logic [3:0] op;
        for (int k = 0; k < 4; k++) begin
            a = 1'($urandom); z = 1'($urandom); op = 4'($urandom);
            tick(a, op, z, 1'b1);
            g = got(); e = model(PH_RST, op, z, a, 1'b0); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL reset k=%0d: got %h want %h", k, g, e); end
        end
        tick(1'b0, 4'h3, 1'b0, 1'b0);
        g = got(); e = model(PH_FETCH, 4'h3, 1'b0, 1'b0, 1'b0); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL reset_exit: got %h want %h", g, e); end
    endtask

    // LDI with ack on third FETCH cycle
    task automatic test_ldi();
        logic a;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            a = (k == 2);
            tick(a, 4'h1, 1'b0, 1'b0);
            g = got(); e = model(PH_FETCH, 4'h1, 1'b0, a, 1'b0); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL ldi_fetch k=%0d: got %h want %h", k, g, e); end
        end
        tick(1'b0, 4'h1, 1'b0, 1'b0);
        g = got(); e = model(PH_DECODE, 4'h1, 1'b0, 1'b0, 1'b0); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL ldi_decode: got %h want %h", g, e); end
        tick(1'b0, 4'h1, 1'b0, 1'b0);
        g = got(); e = model(PH_EXEC, 4'h1, 1'b0, 1'b0, 1'b0); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL ldi_exec: got %h want %h", g, e); end
        tick(1'b0, 4'h1, 1'b0, 1'b0);
        g = got(); e = model(PH_FETCH, 4'h1, 1'b0, 1'b0, 1'b0); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL ldi_refetch: got %h want %h", g, e); end
    endtask

    // JZ taken only when zero_flag is set
    task automatic test_jz();
        logic z;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            z = (r == 1);
            tick(1'b1, 4'hC, z, 1'b0);
            tick(1'b0, 4'hC, z, 1'b0);
            tick(1'b0, 4'hC, z, 1'b0);
            g = got(); e = model(PH_EXEC, 4'hC, z, 1'b0, 1'b0); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL jz run=%0d: got %h want %h", r, g, e); end
            if (loadPC !== z) begin n_bad++; $display("FAIL jz_loadpc run=%0d: got %b want %b", r, loadPC, z); end
            n_cmp++;
        end
    endtask

    // Store: three MEM cycles, ack on the third
    task automatic test_st();
        logic a;
        do_reset();
        tick(1'b1, 4'hE, 1'b0, 1'b0);
        tick(1'b0, 4'hE, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            a = (k == 2);
            tick(a, 4'hE, 1'b0, 1'b0);
            g = got(); e = model(PH_MEM, 4'hE, 1'b0, a, 1'b0); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL st_mem k=%0d: got %h want %h", k, g, e); end
        end
        tick(1'b0, 4'hE, 1'b0, 1'b0);
        g = got(); e = model(PH_FETCH, 4'hE, 1'b0, 1'b0, 1'b0); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL st_done: got %h want %h", g, e); end
    endtask

    // No ack: 15 request cycles, then fault+halt held until reset
    task automatic test_fetch_timeout();
        logic a;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            g = got(); e = model(PH_FETCH, 4'h0, 1'b0, 1'b0, 1'b0); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL to_wait k=%0d: got %h want %h", k, g, e); end
        end
        for (int k = 0; k < 4; k++) begin
            a = 1'($urandom);
            tick(a, 4'($urandom), 1'b0, 1'b0);
            g = got(); e = model(PH_HALT, 4'h0, 1'b0, a, 1'b1); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL to_halt k=%0d: got %h want %h", k, g, e); end
        end
        tick(1'b0, 4'h0, 1'b0, 1'b1);
        g = got(); e = model(PH_RST, 4'h0, 1'b0, 1'b0, 1'b1); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL to_rst: got %h want %h", g, e); end
        tick(1'b0, 4'h0, 1'b0, 1'b0);
        g = got(); e = model(PH_FETCH, 4'h0, 1'b0, 1'b0, 1'b0); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL to_recover: got %h want %h", g, e); end
    endtask

    // Ack on the last allowed cycle wins over timeout; then a LD that times out in MEM
    task automatic test_ack_on_timeout();
        logic a;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            a = (k == 14);
            tick(a, 4'hD, 1'b0, 1'b0);
            g = got(); e = model(PH_FETCH, 4'hD, 1'b0, a, 1'b0); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL ackwin k=%0d: got %h want %h", k, g, e); end
        end
        tick(1'b0, 4'hD, 1'b0, 1'b0);
        g = got(); e = model(PH_DECODE, 4'hD, 1'b0, 1'b0, 1'b0); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL ackwin_decode: got %h want %h", g, e); end
        for (int k = 0; k < 15; k++) begin
            tick(1'b0, 4'hD, 1'b0, 1'b0);
            g = got(); e = model(PH_MEM, 4'hD, 1'b0, 1'b0, 1'b0); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL memto k=%0d: got %h want %h", k, g, e); end
        end
        tick(1'b1, 4'hD, 1'b0, 1'b0);
        g = got(); e = model(PH_HALT, 4'hD, 1'b0, 1'b1, 1'b1); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL memto_halt: got %h want %h", g, e); end
    endtask

    // HALT opcode: stray acks ignored, reset returns to FETCH with fault clear
    task automatic test_halt();
        logic a;
        do_reset();
        tick(1'b1, 4'hF, 1'b0, 1'b0);
        tick(1'b0, 4'hF, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            a = 1'($urandom);
            tick(a, 4'hF, 1'($urandom), 1'b0);
            g = got(); e = model(PH_HALT, 4'hF, 1'b0, a, 1'b0); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL halt k=%0d: got %h want %h", k, g, e); end
        end
        tick(1'b1, 4'hF, 1'b0, 1'b1);
        tick(1'b0, 4'hF, 1'b0, 1'b0);
        g = got(); e = model(PH_FETCH, 4'hF, 1'b0, 1'b0, 1'b0); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL halt_exit: got %h want %h", g, e); end
    endtask

    // Reset while a LD waits in MEM: ack coincident with rst must not load
    task automatic test_rst_mid_mem();
        do_reset();
        tick(1'b1, 4'hD, 1'b0, 1'b0);
        tick(1'b0, 4'hD, 1'b0, 1'b0);
        tick(1'b0, 4'hD, 1'b0, 1'b0);
        tick(1'b0, 4'hD, 1'b0, 1'b0);
        tick(1'b1, 4'hD, 1'b0, 1'b1);
        g = got(); e = model(PH_RST, 4'hD, 1'b0, 1'b1, 1'b0); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL rstmem_zero: got %h want %h", g, e); end
        tick(1'b0, 4'hD, 1'b0, 1'b0);
        g = got(); e = model(PH_FETCH, 4'hD, 1'b0, 1'b0, 1'b0); n_cmp++;
        if (g !== e) begin n_bad++; $display("FAIL rstmem_fetch: got %h want %h", g, e); end
    endtask

    // Random instruction stream with random ack delays and stray acks
    task automatic test_random();
        logic [3:0] op, junk;
        logic a, z;
        int fd, md;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 14));
            fd = $urandom_range(0, 5);
            md = $urandom_range(0, 5);
            for (int k = 0; k <= fd; k++) begin
                a = (k == fd); junk = 4'($urandom); z = 1'($urandom);
                tick(a, junk, z, 1'b0);
                g = got(); e = model(PH_FETCH, junk, z, a, 1'b0); n_cmp++;
                if (g !== e) begin n_bad++; $display("FAIL rnd_fetch i=%0d k=%0d: got %h want %h", i, k, g, e); end
            end
            a = 1'($urandom); z = 1'($urandom);
            tick(a, op, z, 1'b0);
            g = got(); e = model(PH_DECODE, op, z, a, 1'b0); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL rnd_decode i=%0d op=%h: got %h want %h", i, op, g, e); end
            if (op == 4'hD || op == 4'hE) begin
                for (int k = 0; k <= md; k++) begin
                    a = (k == md); z = 1'($urandom);
                    tick(a, op, z, 1'b0);
                    g = got(); e = model(PH_MEM, op, z, a, 1'b0); n_cmp++;
                    if (g !== e) begin n_bad++; $display("FAIL rnd_mem i=%0d op=%h k=%0d: got %h want %h", i, op, k, g, e); end
                end
            end else begin
                a = 1'($urandom); z = 1'($urandom);
                tick(a, op, z, 1'b0);
                g = got(); e = model(PH_EXEC, op, z, a, 1'b0); n_cmp++;
                if (g !== e) begin n_bad++; $display("FAIL rnd_exec i=%0d op=%h z=%b: got %h want %h", i, op, z, g, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_jz();
        test_st();
        test_fetch_timeout();
        test_ack_on_timeout();
        test_halt();
        test_rst_mid_mem();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max cycles waiting on mem_ack before abort (4-bit counter).
REQ-002 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port opcode  input  4  opcode from instruction register, valid from DECODE onward.
REQ-005 SHALL have port zero_flag  input  1  accumulator-zero flag from datapath.
REQ-006 SHALL have port mem_ack  input  1  memory completion strobe, one cycle.
REQ-007 SHALL have port mem_req  output  1  memory request, held until ack or timeout.
REQ-008 SHALL have port mem_we  output  1  write qualifier, valid only with mem_req.
REQ-009 SHALL have port mem_sel_pc  output  1  1 = address from PC (fetch), 0 = from imed_reg (data).
REQ-010 SHALL have port loadIR  output  1  instruction register load pulse.
REQ-011 SHALL have port incPC  output  1  PC increment pulse.
REQ-012 SHALL have port loadPC  output  1  PC load-from-immediate pulse.
REQ-013 SHALL have port alu_op  output  4  ALU function, equals opcode during EXEC, else 0.
REQ-014 SHALL have port sel_imm  output  1  ALU operand B = immediate (1) or register (0).
REQ-015 SHALL have port acc_load  output  1  accumulator write pulse.
REQ-016 SHALL have port reg_write  output  1  register-file write pulse (acc -> reg).
REQ-017 SHALL have port halted  output  1  high in HALT state.
REQ-018 SHALL have port fault  output  1  sticky, set on memory timeout.

Function
REQ-019 SHALL implement states FETCH, DECODE, EXEC, MEM, HALT.
REQ-020 FETCH: mem_req=1, mem_sel_pc=1; on mem_ack assert loadIR same cycle, next DECODE; else stay.
REQ-021 DECODE: incPC=1 exactly one cycle; next HALT if opcode=F, MEM if D/E, else EXEC.
REQ-022 EXEC, one cycle, then FETCH; classes: 0 NOP none; 1 LDI, 8 ADDI: acc_load, sel_imm; 2-7 ALU reg: acc_load, sel_imm=0; 9 MOV acc->reg: reg_write; A MOV reg->acc: acc_load; B JMP: loadPC; C JZ: loadPC=zero_flag.
REQ-023 MEM: mem_req=1, mem_sel_pc=0, mem_we=(opcode=E); on mem_ack, LD (D) asserts acc_load same cycle; next FETCH.
REQ-024 HALT: halted=1, all other pulses 0, exit only via rst.
REQ-025 Wait counter SHALL clear on entry to FETCH/MEM; at MEM_TIMEOUT cycles without ack: drop mem_req, set fault, go HALT.
REQ-026 mem_ack outside FETCH/MEM SHALL be ignored; ack on timeout cycle SHALL be honoured (ack wins).
REQ-027 Pulse outputs SHALL be combinational from state, opcode, mem_ack, zero_flag; no pulse longer than one cycle except mem_req.
REQ-028 At most one of loadPC/incPC SHALL be high in any cycle.

Reset
REQ-029 rst high SHALL force state FETCH, counter 0, fault 0 at next edge.
REQ-030 While rst high, all outputs SHALL be 0 regardless of state.
REQ-031 rst mid-MEM SHALL abandon the access; no acc_load or mem_we after rst asserts.

Structure
REQ-032 ctrl_pkg SHALL hold opcode constants (OP_NOP..OP_HALT), state encoding, MEM_TIMEOUT default.
REQ-033 Opcode-class decode SHALL be sub-module op_decode (combinational, opcode -> class flags).

Verification
REQ-034 Reset then ack after 2 cycles, opcode=1 -> loadIR on ack cycle, incPC next, acc_load+sel_imm next, FETCH after.
REQ-035 opcode=C, zero_flag=0 then 1 -> loadPC 0 first run, 1 second run.
REQ-036 opcode=E, ack after 3 cycles -> mem_req 3 cycles with mem_we=1, mem_sel_pc=0, no acc_load.
REQ-037 FETCH with no ack 15 cycles -> mem_req drops, fault=1, halted=1; held until rst.
REQ-038 opcode=F -> halted=1 from cycle after DECODE; stray mem_ack ignored; rst returns to FETCH, fault=0.
REQ-039 rst asserted during MEM wait -> all outputs 0, next state FETCH, no writes.
